prefix_addsub_pipe: RTL

PREFIX_ADDSUB_PIPE -- requirements
Module: prefix_addsub_pipe

---
 rtl/prefix_addsub_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/prefix_addsub_pipe.sv
// Pipelined add/sub/neg/abs unit built on a Kogge-Stone prefix adder, split across two stages.
// Define PREFIX_ADDSUB_OVF_EN to add the out_ovf signed-overflow output.
module prefix_addsub_pipe #(
  parameter int N          = 32,
  parameter bit OUT_REG_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_zero,
  output logic         out_neg
`ifdef PREFIX_ADDSUB_OVF_EN
  ,
  output logic         out_ovf
`endif
);

  localparam int L      = $clog2(N);
  localparam int H      = (L + 1) / 2;
  localparam int STAGES = OUT_REG_EN ? 3 : 2;

  // Group propagate over prefix levels [lo, hi)
  function automatic logic [N-1:0] ks_p(input logic [N-1:0] p, input int lo, input int hi);
    logic [N-1:0] pc, pn;
    pc = p;
    for (int k = lo; k < hi; k++) begin
      pn = pc;
      for (int i = (1 << k); i < N; i++) pn[i] = pc[i] & pc[i - (1 << k)];
      pc = pn;
    end
    return pc;
  endfunction

  // Group generate over prefix levels [lo, hi)
  function automatic logic [N-1:0] ks_g(input logic [N-1:0] g, input logic [N-1:0] p,
                                        input int lo, input int hi);
    logic [N-1:0] gc, pc, gn, pn;
    gc = g;
    pc = p;
    for (int k = lo; k < hi; k++) begin
      gn = gc;
      pn = pc;
      for (int i = (1 << k); i < N; i++) begin
        gn[i] = gc[i] | (pc[i] & gc[i - (1 << k)]);
        pn[i] = pc[i] & pc[i - (1 << k)];
      end
      gc = gn;
      pc = pn;
    end
    return gc;
  endfunction

  logic [STAGES:1] vld_pipe;

  assign out_valid = vld_pipe[STAGES];
  assign in_ready  = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset)         vld_pipe <= '0;
    else if (in_ready) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Operand mapping: every op becomes X + Y + cin
  logic [N-1:0] xs, ys;
  logic         cs;
  always_comb begin
    xs = in_a;
    ys = in_b;
    cs = 1'b0;
    case (in_op)
      2'b01: begin ys = ~in_b; cs = 1'b1; end
      2'b10: begin xs = ~in_a; ys = '0; cs = 1'b1; end
      2'b11: begin
        ys = '0;
        if (in_a[N-1]) begin xs = ~in_a; cs = 1'b1; end
      end
      default: ;
    endcase
  end

  logic [N-1:0] x1, y1;
  logic         cin1;
`ifdef PREFIX_ADDSUB_OVF_EN
  logic [1:0]   op1;
  logic         amin1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      x1 <= '0; y1 <= '0; cin1 <= 1'b0;
`ifdef PREFIX_ADDSUB_OVF_EN
      op1 <= '0; amin1 <= 1'b0;
`endif
    end else if (in_ready) begin
      x1 <= xs; y1 <= ys; cin1 <= cs;
`ifdef PREFIX_ADDSUB_OVF_EN
      op1   <= in_op;
      amin1 <= (in_a == {1'b1, {(N-1){1'b0}}});
`endif
    end
  end

  // Stage 2: bitwise G/P with cin folded into bit 0, then the first H prefix levels
  logic [N-1:0] g0, p0, gh, ph;
  always_comb begin
    g0    = x1 & y1;
    p0    = x1 ^ y1;
    g0[0] = g0[0] | (p0[0] & cin1);
    gh    = ks_g(g0, p0, 0, H);
    ph    = ks_p(p0, 0, H);
  end

  logic [N-1:0] g2, p2, pb2;
  logic         cin2;
`ifdef PREFIX_ADDSUB_OVF_EN
  logic [1:0]   op2;
  logic         amin2, xs2, ys2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      g2 <= '0; p2 <= '0; pb2 <= '0; cin2 <= 1'b0;
`ifdef PREFIX_ADDSUB_OVF_EN
      op2 <= '0; amin2 <= 1'b0; xs2 <= 1'b0; ys2 <= 1'b0;
`endif
    end else if (in_ready) begin
      g2 <= gh; p2 <= ph; pb2 <= p0; cin2 <= cin1;
`ifdef PREFIX_ADDSUB_OVF_EN
      op2 <= op1; amin2 <= amin1; xs2 <= x1[N-1]; ys2 <= y1[N-1];
`endif
    end
  end

  // Stage 3: remaining prefix levels, sum and flags
  logic [N-1:0] gf, sum3;
  logic         cout3, zero3, neg3;
  always_comb begin
    gf    = ks_g(g2, p2, H, L);
    sum3  = pb2 ^ {gf[N-2:0], cin2};
    cout3 = gf[N-1];
    zero3 = (sum3 == '0);
    neg3  = sum3[N-1];
  end

`ifdef PREFIX_ADDSUB_OVF_EN
  logic ovf3;
  assign ovf3 = op2[1] ? amin2 : ((xs2 == ys2) && (sum3[N-1] != xs2));
`endif

  if (OUT_REG_EN) begin : g_oreg
    always_ff @(posedge clk) begin
      if (reset) begin
        out_sum <= '0; out_cout <= 1'b0; out_zero <= 1'b0; out_neg <= 1'b0;
`ifdef PREFIX_ADDSUB_OVF_EN
        out_ovf <= 1'b0;
`endif
      end else if (in_ready) begin
        out_sum <= sum3; out_cout <= cout3; out_zero <= zero3; out_neg <= neg3;
`ifdef PREFIX_ADDSUB_OVF_EN
        out_ovf <= ovf3;
`endif
      end
    end
  end else begin : g_ocomb
    // Cleared stage-2 state yields sum 0, so zero is qualified to read 0 out of reset
    assign out_sum  = sum3;
    assign out_cout = cout3;
    assign out_zero = zero3 & vld_pipe[STAGES];
    assign out_neg  = neg3;
`ifdef PREFIX_ADDSUB_OVF_EN
    assign out_ovf  = ovf3;
`endif
  end

endmodule
